multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_ctrl_pkg.sv | 66 ++++++
 rtl/mc_ctrl_if.sv | 47 ++++
 rtl/mc_alu_decode.sv | 29 ++
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multicycle controller.
//   - state encoding (4-bit state codes exported on state_out)
//   - opcode / func field constants
//   - ALU operation codes, alu_src_b selector codes, mem_read size codes
package mc_ctrl_pkg;

    localparam int unsigned StateW = 4;

    typedef enum logic [StateW-1:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StIExec  = 4'd9,
        StIWb    = 4'd10
    } state_e;

    // Opcodes, instruction[31:26]
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpLh    = 6'b100001;
    localparam logic [5:0] OpLhu   = 6'b100101;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;

    // R-type func field, instruction[5:0]
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnSrl  = 6'b000010;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnSlt  = 6'b101010;
    localparam logic [5:0] FnSltu = 6'b101011;

    // ALU operation codes
    localparam logic [2:0] AluAdd  = 3'd0;
    localparam logic [2:0] AluSub  = 3'd1;
    localparam logic [2:0] AluSll  = 3'd2;
    localparam logic [2:0] AluSrl  = 3'd3;
    localparam logic [2:0] AluAnd  = 3'd4;
    localparam logic [2:0] AluOr   = 3'd5;
    localparam logic [2:0] AluSlt  = 3'd6;
    localparam logic [2:0] AluSltu = 3'd7;

    // ALU operand B selector
    localparam logic [1:0] SrcBReg   = 2'd0;
    localparam logic [1:0] SrcBFour  = 2'd1;
    localparam logic [1:0] SrcBImm   = 2'd2;
    localparam logic [1:0] SrcBImmS2 = 2'd3;

    // Memory read size
    localparam logic [1:0] MemRdNone  = 2'd0;
    localparam logic [1:0] MemRdWord  = 2'd1;
    localparam logic [1:0] MemRdHalf  = 2'd2;
    localparam logic [1:0] MemRdHalfU = 2'd3;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the multicycle controller and its datapath.
//   Datapath -> controller : opcode, func, zero, mem_ready
//   Controller -> datapath : PC/IR/mux/memory/register-file/ALU controls,
//                            state_out, illegal / timeout error pulses
// Modports: master = controller side, slave = datapath side.
interface mc_ctrl_if
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALU_SEL_W = 3
);
    logic [5:0]           opcode;
    logic [5:0]           func;
    logic                 zero;
    logic                 mem_ready;

    logic                 pc_write;
    logic                 pc_write_cond;
    logic                 pc_src;
    logic                 iord;
    logic                 ir_write;
    logic [1:0]           mem_read;
    logic                 mem_write;
    logic                 reg_dst;
    logic                 mem_to_reg;
    logic                 reg_write;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic [StateW-1:0]    state_out;
    logic                 illegal;
    logic                 timeout;

    modport master (
        input  opcode, func, zero, mem_ready,
        output pc_write, pc_write_cond, pc_src, iord, ir_write, mem_read, mem_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_sel,
               state_out, illegal, timeout
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_src, iord, ir_write, mem_read, mem_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_sel,
               state_out, illegal, timeout
    );

endinterface

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: maps the R-type func field to an ALU operation code.
//   i_func     : instruction[5:0]
//   o_alu_sel  : ALU operation code (add when func is not recognised)
//   o_valid    : func is one of the supported R-type operations
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_func,
    output logic [2:0] o_alu_sel,
    output logic       o_valid
);

    always_comb begin
        o_alu_sel = AluAdd;
        o_valid   = 1'b1;
        case (i_func)
            FnAdd:   o_alu_sel = AluAdd;
            FnSub:   o_alu_sel = AluSub;
            FnSll:   o_alu_sel = AluSll;
            FnSrl:   o_alu_sel = AluSrl;
            FnAnd:   o_alu_sel = AluAnd;
            FnOr:    o_alu_sel = AluOr;
            FnSlt:   o_alu_sel = AluSlt;
            FnSltu:  o_alu_sel = AluSltu;
            default: o_valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle MIPS-style datapath.
//   i_clk   : single clock, all state changes on the rising edge
//   i_reset : synchronous active-high reset; forces every output to 0
//   bus     : mc_ctrl_if.master -- opcode/func/zero/mem_ready in, all
//             datapath controls, state_out and illegal/timeout pulses out
// Parameters: ALU_SEL_W (>= 3) width of alu_sel, WAIT_MAX (>= 1) number of
// consecutive mem_ready=0 cycles tolerated in FETCH/MEMRD/MEMWR.
// Build option: define MC_CTRL_HALFWORD_EN to accept LH/LHU; otherwise those
// opcodes are reported as illegal and mem_read is only ever 0 or 1.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALU_SEL_W = 3,
    parameter int unsigned WAIT_MAX  = 15
) (
    input  logic      i_clk,
    input  logic      i_reset,
    mc_ctrl_if.master bus
);

    localparam int unsigned WaitW = $clog2(WAIT_MAX + 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [WaitW-1:0] r_wait;
    logic [WaitW-1:0] w_wait_next;
    logic             w_wait_hit;
    logic [2:0]       w_fn_alu;
    logic             w_fn_valid;
    logic [2:0]       w_imm_alu;
    logic [1:0]       w_ld_mode;
    logic [2:0]       w_alu;
    logic             w_unused_zero;

    // The branch decision (pc_write_cond & zero) is made in the datapath.
    assign w_unused_zero = bus.zero;

    mc_alu_decode u_alu_decode (
        .i_func    (bus.func),
        .o_alu_sel (w_fn_alu),
        .o_valid   (w_fn_valid)
    );

    // This cycle would be the WAIT_MAX-th consecutive wait; mem_ready wins.
    assign w_wait_hit = !bus.mem_ready && (r_wait == WaitW'(WAIT_MAX - 1));

    always_comb begin
        case (bus.opcode)
            OpAndi:  w_imm_alu = AluAnd;
            OpOri:   w_imm_alu = AluOr;
            default: w_imm_alu = AluAdd;
        endcase
    end

`ifdef MC_CTRL_HALFWORD_EN
    always_comb begin
        case (bus.opcode)
            OpLh:    w_ld_mode = MemRdHalf;
            OpLhu:   w_ld_mode = MemRdHalfU;
            default: w_ld_mode = MemRdWord;
        endcase
    end
`else
    assign w_ld_mode = MemRdWord;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StFetch;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_wait_next       = '0;
        w_alu             = AluAdd;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_read      = MemRdNone;
        bus.mem_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SrcBReg;
        bus.illegal       = 1'b0;
        bus.timeout       = 1'b0;

        // Reset leaves every output at its default of 0.
        if (!i_reset) begin
            case (r_state)
                StFetch: begin
                    bus.mem_read  = MemRdWord;
                    bus.alu_src_b = SrcBFour;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        w_state_next = StDecode;
                    end else if (w_wait_hit) begin
                        bus.timeout = 1'b1;
                    end else begin
                        w_wait_next = r_wait + WaitW'(1);
                    end
                end
                StDecode: begin
                    bus.alu_src_b = SrcBImmS2;
                    case (bus.opcode)
                        OpRtype:                 w_state_next = StExec;
                        OpLw, OpSw:              w_state_next = StMemAdr;
`ifdef MC_CTRL_HALFWORD_EN
                        OpLh, OpLhu:             w_state_next = StMemAdr;
`endif
                        OpBeq:                   w_state_next = StBranch;
                        OpAddi, OpAndi, OpOri:   w_state_next = StIExec;
                        default: begin
                            bus.illegal  = 1'b1;
                            w_state_next = StFetch;
                        end
                    endcase
                end
                StExec: begin
                    bus.alu_src_a = 1'b1;
                    w_alu         = w_fn_alu;
                    if (w_fn_valid) begin
                        w_state_next = StRwb;
                    end else begin
                        bus.illegal  = 1'b1;
                        w_state_next = StFetch;
                    end
                end
                StRwb: begin
                    bus.alu_src_a = 1'b1;
                    w_alu         = w_fn_alu;
                    bus.reg_dst   = 1'b1;
                    bus.reg_write = 1'b1;
                    w_state_next  = StFetch;
                end
                StMemAdr: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SrcBImm;
                    w_state_next  = (bus.opcode == OpSw) ? StMemWr : StMemRd;
                end
                StMemRd: begin
                    bus.iord     = 1'b1;
                    bus.mem_read = w_ld_mode;
                    if (bus.mem_ready) begin
                        w_state_next = StMemWb;
                    end else if (w_wait_hit) begin
                        bus.timeout  = 1'b1;
                        w_state_next = StFetch;
                    end else begin
                        w_wait_next = r_wait + WaitW'(1);
                    end
                end
                StMemWb: begin
                    bus.mem_to_reg = 1'b1;
                    bus.reg_write  = 1'b1;
                    w_state_next   = StFetch;
                end
                StMemWr: begin
                    bus.iord      = 1'b1;
                    bus.mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        w_state_next = StFetch;
                    end else if (w_wait_hit) begin
                        bus.timeout  = 1'b1;
                        w_state_next = StFetch;
                    end else begin
                        w_wait_next = r_wait + WaitW'(1);
                    end
                end
                StBranch: begin
                    bus.alu_src_a     = 1'b1;
                    w_alu             = AluSub;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_src        = 1'b1;
                    w_state_next      = StFetch;
                end
                StIExec: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SrcBImm;
                    w_alu         = w_imm_alu;
                    w_state_next  = StIWb;
                end
                StIWb: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SrcBImm;
                    w_alu         = w_imm_alu;
                    bus.reg_write = 1'b1;
                    w_state_next  = StFetch;
                end
                default: w_state_next = StFetch;
            endcase
        end
    end

    assign bus.alu_sel   = ALU_SEL_W'(w_alu);
    assign bus.state_out = i_reset ? '0 : r_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mc_ctrl_if #(.ALU_SEL_W(3)) bus ();

    multicycle_control #(
        .ALU_SEL_W (3),
        .WAIT_MAX  (15)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // {pcw,pcc,pcs,iord,irw,mem_read[2],mw,rd,m2r,rw,a,b[2],sel[3],state[4],ill,to}
    logic [22:0] obs;
    assign obs = {bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.iord, bus.ir_write,
                  bus.mem_read, bus.mem_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_sel, bus.state_out, bus.illegal,
                  bus.timeout};

    function automatic logic [22:0] pk(input logic pcw, pcc, pcs, iord, irw,
                                       input logic [1:0] mr, input logic mw, rd, m2r, rw, a,
                                       input logic [1:0] b, input logic [2:0] sel,
                                       input logic [3:0] st, input logic ill, to);
        return {pcw, pcc, pcs, iord, irw, mr, mw, rd, m2r, rw, a, b, sel, st, ill, to};
    endfunction

    logic [22:0] e_frdy, e_fwait, e_dec, e_madr;
    logic [22:0] e [8];
    logic        r [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        repeat (2) step();
        n_total++;
        if (obs !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_hold got=%h want=%h", obs, 23'd0);
        end
        reset = 1'b0;
        #1;
        n_total++;
        if (obs !== e_fwait) begin
            n_bad++;
            $display("FAIL reset_first_fetch got=%h want=%h", obs, e_fwait);
        end
    endtask

    task automatic test_rtype(input logic [5:0] fn, input logic [2:0] sel, input string nm);
        bus.opcode = 6'b000000;
        bus.func   = fn;
        e[0] = e_frdy; e[1] = e_dec;
        e[2] = pk(0,0,0,0,0, 2'd0,0,0,0,0,1, 2'd0,sel,4'd6,0,0);
        e[3] = pk(0,0,0,0,0, 2'd0,0,1,0,1,1, 2'd0,sel,4'd7,0,0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            n_total++;
            if (obs !== e[i]) begin
                n_bad++;
                $display("FAIL rtype_%0s step%0d got=%h want=%h", nm, i, obs, e[i]);
            end
            step();
        end
        n_total++;
        if (bus.state_out !== 4'd0) begin
            n_bad++;
            $display("FAIL rtype_%0s_ret got=%0d want=0", nm, bus.state_out);
        end
    endtask

    task automatic test_load_wait();
        bus.opcode = 6'b100011;
        e[0] = e_frdy; r[0] = 1;
        e[1] = e_dec;  r[1] = 1;
        e[2] = e_madr; r[2] = 1;
        e[3] = pk(0,0,0,1,0, 2'd1,0,0,0,0,0, 2'd0,3'd0,4'd3,0,0); r[3] = 0;
        e[4] = e[3]; r[4] = 0;
        e[5] = e[3]; r[5] = 1;
        e[6] = pk(0,0,0,0,0, 2'd0,0,0,1,1,0, 2'd0,3'd0,4'd4,0,0); r[6] = 1;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = r[i];
            #1;
            n_total++;
            if (obs !== e[i]) begin
                n_bad++;
                $display("FAIL lw_wait step%0d got=%h want=%h", i, obs, e[i]);
            end
            step();
        end
        n_total++;
        if (bus.state_out !== 4'd0) begin
            n_bad++;
            $display("FAIL lw_wait_ret got=%0d want=0", bus.state_out);
        end
    endtask

    task automatic test_store();
        bus.opcode = 6'b101011;
        e[0] = e_frdy; e[1] = e_dec; e[2] = e_madr;
        e[3] = pk(0,0,0,1,0, 2'd0,1,0,0,0,0, 2'd0,3'd0,4'd5,0,0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            n_total++;
            if (obs !== e[i]) begin
                n_bad++;
                $display("FAIL sw step%0d got=%h want=%h", i, obs, e[i]);
            end
            step();
        end
        n_total++;
        if (bus.state_out !== 4'd0) begin
            n_bad++;
            $display("FAIL sw_ret got=%0d want=0", bus.state_out);
        end
    endtask

    task automatic test_branch();
        bus.opcode = 6'b000100;
        bus.zero   = 1'b1;
        e[0] = e_frdy; e[1] = e_dec;
        e[2] = pk(0,1,1,0,0, 2'd0,0,0,0,0,1, 2'd0,3'd1,4'd8,0,0);
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            n_total++;
            if (obs !== e[i]) begin
                n_bad++;
                $display("FAIL beq step%0d got=%h want=%h", i, obs, e[i]);
            end
            step();
        end
        bus.zero = 1'b0;
        n_total++;
        if (bus.state_out !== 4'd0) begin
            n_bad++;
            $display("FAIL beq_ret got=%0d want=0", bus.state_out);
        end
    endtask

    task automatic test_itype();
        bus.opcode = 6'b001100;
        e[0] = e_frdy; e[1] = e_dec;
        e[2] = pk(0,0,0,0,0, 2'd0,0,0,0,0,1, 2'd2,3'd4,4'd9,0,0);
        e[3] = pk(0,0,0,0,0, 2'd0,0,0,0,1,1, 2'd2,3'd4,4'd10,0,0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            n_total++;
            if (obs !== e[i]) begin
                n_bad++;
                $display("FAIL andi step%0d got=%h want=%h", i, obs, e[i]);
            end
            step();
        end
        n_total++;
        if (bus.state_out !== 4'd0) begin
            n_bad++;
            $display("FAIL andi_ret got=%0d want=0", bus.state_out);
        end
    endtask

    task automatic test_illegal();
        // Unknown opcode: illegal pulse in DECODE.
        bus.opcode = 6'b111111;
        e[0] = e_frdy;
        e[1] = pk(0,0,0,0,0, 2'd0,0,0,0,0,0, 2'd3,3'd0,4'd1,1,0);
        // Unknown func: illegal pulse in EXEC, no RWB.
        e[2] = e_frdy; e[3] = e_dec;
        e[4] = pk(0,0,0,0,0, 2'd0,0,0,0,0,1, 2'd0,3'd0,4'd6,1,0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.opcode = 6'b000000;
                bus.func   = 6'b111111;
            end
            bus.mem_ready = 1'b1;
            #1;
            n_total++;
            if (obs !== e[i]) begin
                n_bad++;
                $display("FAIL illegal step%0d got=%h want=%h", i, obs, e[i]);
            end
            step();
        end
        n_total++;
        if (bus.state_out !== 4'd0) begin
            n_bad++;
            $display("FAIL illegal_ret got=%0d want=0", bus.state_out);
        end
    endtask

    task automatic test_halfword();
        int n;
        bus.opcode = 6'b100001;
        e[0] = e_frdy;
`ifdef MC_CTRL_HALFWORD_EN
        e[1] = e_dec; e[2] = e_madr;
        e[3] = pk(0,0,0,1,0, 2'd2,0,0,0,0,0, 2'd0,3'd0,4'd3,0,0);
        e[4] = pk(0,0,0,0,0, 2'd0,0,0,1,1,0, 2'd0,3'd0,4'd4,0,0);
        n = 5;
`else
        e[1] = pk(0,0,0,0,0, 2'd0,0,0,0,0,0, 2'd3,3'd0,4'd1,1,0);
        n = 2;
`endif
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            n_total++;
            if (obs !== e[i]) begin
                n_bad++;
                $display("FAIL lh step%0d got=%h want=%h", i, obs, e[i]);
            end
            step();
        end
        n_total++;
        if (bus.state_out !== 4'd0) begin
            n_bad++;
            $display("FAIL lh_ret got=%0d want=0", bus.state_out);
        end
    endtask

    task automatic test_timeout();
        logic [22:0] want;
        bus.opcode = 6'b000100;
        // 15 waits -> timeout on the 15th; then 14 waits and ready on the 15th wins.
        for (int k = 1; k <= 30; k++) begin
            bus.mem_ready = (k == 30);
            #1;
            if (k == 30) want = e_frdy;
            else want = pk(0,0,0,0,0, 2'd1,0,0,0,0,0, 2'd1,3'd0,4'd0,0,(k == 15));
            n_total++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL timeout cycle%0d got=%h want=%h", k, obs, want);
            end
            step();
        end
        n_total++;
        if (obs !== e_dec) begin
            n_bad++;
            $display("FAIL timeout_ready_wins got=%h want=%h", obs, e_dec);
        end
        repeat (2) step();
        n_total++;
        if (bus.state_out !== 4'd0) begin
            n_bad++;
            $display("FAIL timeout_ret got=%0d want=0", bus.state_out);
        end
    endtask

    task automatic test_reset_midway();
        bus.opcode = 6'b101011;
        bus.mem_ready = 1'b1;
        repeat (3) step();
        bus.mem_ready = 1'b0;
        #1;
        n_total++;
        if (bus.state_out !== 4'd5 || bus.mem_write !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_memwr got=%0d/%b want=5/1", bus.state_out, bus.mem_write);
        end
        step();
        reset = 1'b1;
        #1;
        n_total++;
        if (obs !== 23'd0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs got=%h want=%h", obs, 23'd0);
        end
        step();
        reset = 1'b0;
        #1;
        n_total++;
        if (obs !== e_fwait) begin
            n_bad++;
            $display("FAIL rst_mid_refetch got=%h want=%h", obs, e_fwait);
        end
    endtask

    initial begin
        e_frdy  = pk(1,0,0,0,1, 2'd1,0,0,0,0,0, 2'd1,3'd0,4'd0,0,0);
        e_fwait = pk(0,0,0,0,0, 2'd1,0,0,0,0,0, 2'd1,3'd0,4'd0,0,0);
        e_dec   = pk(0,0,0,0,0, 2'd0,0,0,0,0,0, 2'd3,3'd0,4'd1,0,0);
        e_madr  = pk(0,0,0,0,0, 2'd0,0,0,0,0,1, 2'd2,3'd0,4'd2,0,0);
        bus.opcode    = 6'd0;
        bus.func      = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        test_reset();
        test_rtype(6'b100000, 3'd0, "add");
        test_rtype(6'b101011, 3'd7, "sltu");
        test_rtype(6'b000010, 3'd3, "srl");
        test_load_wait();
        test_store();
        test_branch();
        test_itype();
        test_illegal();
        test_halfword();
        test_timeout();
        test_reset_midway();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
